max_search_engine: RTL and testbench

Memory-side initiator that scans a contiguous block of words in the single-port data memory, finds the largest signed element and its index, and writes both results back to fixed result locations. It drives the same request signals the datapath uses (address, write data, read and write strobes) and consumes the memory's combinational read value. It is the hardware engine behind the max-element benchmark, and it owns the memory port only while `busy` or `done` is high.

---
 rtl/max_search_engine.sv | 151 +++++++++++++++
 tb/tb_max_search_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_search_engine.sv
// Scans count signed words from base_addr, tracks max/index, optionally writes them to MAX_ADDR/IDX_ADDR (MAX_SEARCH_WRITEBACK_EN).
// Latency start->done: count+3 with writeback, count+1 without, 1 for count=0; no backpressure, memory is combinational.
module max_search_engine #(
    parameter logic [31:0] MAX_ADDR = 32'd2000,
    parameter logic [31:0] IDX_ADDR = 32'd2004,
    parameter logic [31:0] STRIDE   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] count,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        Mem_read,
    output logic        Mem_write,
    input  logic [31:0] Mem_read_value,
    output logic        busy,
    output logic        done,
    output logic [31:0] max_value,
    output logic [15:0] max_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_MAX,
        S_WR_IDX,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_base;
    logic [15:0] r_count;
    logic [15:0] r_i;
    logic [31:0] r_max_value;
    logic [15:0] r_max_index;

    logic [31:0] w_rd_addr;
    logic        w_last;
    logic        w_greater;

    assign w_rd_addr = r_base + ({16'b0, r_i} * STRIDE);
    assign w_last    = (r_i == (r_count - 16'd1));
    assign w_greater = $signed(Mem_read_value) > $signed(r_max_value);

    assign max_value = r_max_value;
    assign max_index = r_max_index;

`ifndef MAX_SEARCH_WRITEBACK_EN
    logic w_unused_wb;
    assign w_unused_wb = ^{MAX_ADDR, IDX_ADDR};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        Address    = 32'd0;
        Write_data = 32'd0;
        Mem_read   = 1'b0;
        Mem_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (count == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                Address  = w_rd_addr;
                Mem_read = 1'b1;
                if (w_last) begin
`ifdef MAX_SEARCH_WRITEBACK_EN
                    w_next = S_WR_MAX;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MAX_SEARCH_WRITEBACK_EN
            S_WR_MAX: begin
                busy       = 1'b1;
                Address    = MAX_ADDR;
                Write_data = r_max_value;
                Mem_write  = 1'b1;
                w_next     = S_WR_IDX;
            end
            S_WR_IDX: begin
                busy       = 1'b1;
                Address    = IDX_ADDR;
                Write_data = {16'b0, r_max_index};
                Mem_write  = 1'b1;
                w_next     = S_DONE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Element 0 seeds the running max unconditionally; strict > keeps the earliest tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= 32'd0;
            r_count     <= 16'd0;
            r_i         <= 16'd0;
            r_max_value <= 32'd0;
            r_max_index <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count == 16'd0) begin
                            r_max_value <= 32'd0;
                            r_max_index <= 16'd0;
                        end else begin
                            r_base  <= base_addr;
                            r_count <= count;
                            r_i     <= 16'd0;
                        end
                    end
                end
                S_READ: begin
                    if ((r_i == 16'd0) || w_greater) begin
                        r_max_value <= Mem_read_value;
                        r_max_index <= r_i;
                    end
                    r_i <= r_i + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_search_engine.sv
// Directed bench for max_search_engine with a combinational-read word memory model.
// Expected latencies follow MAX_SEARCH_WRITEBACK_EN as defined for the build.
module tb_max_search_engine;

`ifdef MAX_SEARCH_WRITEBACK_EN
    localparam int LAT = 3;
    localparam int NWR = 2;
    localparam bit WB  = 1'b1;
`else
    localparam int LAT = 1;
    localparam int NWR = 0;
    localparam bit WB  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        Mem_read;
    logic        Mem_write;
    logic [31:0] Mem_read_value;
    logic        busy;
    logic        done;
    logic [31:0] max_value;
    logic [15:0] max_index;

    logic [31:0] mem [0:4095];
    logic        tb_we;
    logic [11:0] tb_addr;
    logic [31:0] tb_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    max_search_engine dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .count          (count),
        .Address        (Address),
        .Write_data     (Write_data),
        .Mem_read       (Mem_read),
        .Mem_write      (Mem_write),
        .Mem_read_value (Mem_read_value),
        .busy           (busy),
        .done           (done),
        .max_value      (max_value),
        .max_index      (max_index)
    );

    assign Mem_read_value = Mem_read ? mem[Address[11:0]] : 32'h0;

    always @(posedge clk) begin
        if (Mem_write) mem[Address[11:0]] <= Write_data;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Starts one scan and watches it from cycle 1 (first cycle after the accepting edge) until done.
    task automatic run_scan(input logic [31:0] b, input logic [15:0] c,
                            output int dcyc, output int nrd, output int nwr, output int nboth);
        dcyc = -1; nrd = 0; nwr = 0; nboth = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; count = c;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (Mem_read) nrd++;
            if (Mem_write) nwr++;
            if (Mem_read && Mem_write) nboth++;
            if (done) begin
                dcyc = n;
                break;
            end
            @(negedge clk);
        end
        if (dcyc < 0) begin
            total++; bad++;
            $display("FAIL scan_timeout: done not seen within 200 cycles (base=%0d count=%0d)", b, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = 32'd0; count = 16'd0; tb_we = 1'b0;
        tb_addr = 12'd0; tb_wdata = 32'd0;
        #1;
        total++;
        if ({Address, Write_data, Mem_read, Mem_write, busy, done, max_value, max_index} !== 116'd0) begin
            bad++;
            $display("FAIL reset_outputs: got addr=%h wd=%h rd=%b wr=%b busy=%b done=%b max=%h idx=%h, want all 0",
                     Address, Write_data, Mem_read, Mem_write, busy, done, max_value, max_index);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int d, r, w, bth;
        poke(12'd100, 32'd3);
        poke(12'd101, -32'sd7);
        poke(12'd102, 32'd12);
        poke(12'd103, 32'd5);
        poke(12'd104, 32'd12);
        poke(12'd2000, 32'hDEAD_0000);
        poke(12'd2004, 32'hDEAD_0004);
        run_scan(32'd100, 16'd5, d, r, w, bth);
        total++;
        if (d !== 5 + LAT) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", d, 5 + LAT); end
        total++;
        if (max_value !== 32'd12) begin bad++; $display("FAIL basic_max: got %h want 0000000c", max_value); end
        total++;
        if (max_index !== 16'd2) begin bad++; $display("FAIL basic_index: got %0d want 2", max_index); end
        total++;
        if (r !== 5 || w !== NWR || bth !== 0) begin
            bad++; $display("FAIL basic_strobes: reads=%0d writes=%0d both=%0d want 5/%0d/0", r, w, bth, NWR);
        end
        total++;
        if (WB && (mem[2000] !== 32'd12 || mem[2004] !== 32'd2)) begin
            bad++; $display("FAIL basic_writeback: mem2000=%h mem2004=%h want 0000000c/00000002", mem[2000], mem[2004]);
        end else if (!WB && (mem[2000] !== 32'hDEAD_0000 || mem[2004] !== 32'hDEAD_0004)) begin
            bad++; $display("FAIL basic_no_writeback: mem2000=%h mem2004=%h want untouched", mem[2000], mem[2004]);
        end
    endtask

    task automatic test_negatives();
        int d, r, w, bth;
        poke(12'd200, -32'sd9);
        poke(12'd201, -32'sd2);
        poke(12'd202, -32'sd5);
        run_scan(32'd200, 16'd3, d, r, w, bth);
        total++;
        if (max_value !== 32'hFFFF_FFFE || max_index !== 16'd1) begin
            bad++; $display("FAIL neg_signed: got max=%h idx=%0d want fffffffe/1", max_value, max_index);
        end
        total++;
        if (d !== 3 + LAT) begin bad++; $display("FAIL neg_done_cycle: got %0d want %0d", d, 3 + LAT); end
    endtask

    task automatic test_count_zero();
        int d, r, w, bth;
        run_scan(32'd200, 16'd0, d, r, w, bth);
        total++;
        if (d !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", d); end
        total++;
        if (r !== 0 || w !== 0) begin bad++; $display("FAIL zero_strobes: reads=%0d writes=%0d want 0/0", r, w); end
        total++;
        if (max_value !== 32'd0 || max_index !== 16'd0) begin
            bad++; $display("FAIL zero_results: got max=%h idx=%0d want 0/0", max_value, max_index);
        end
    endtask

    task automatic test_reset_mid();
        int d, r, w, bth;
        for (int k = 0; k < 10; k++) poke(12'(300 + k), (k == 7) ? 32'd1000 : 32'(k * 3));
        poke(12'd2000, 32'hA5A5_A5A5);
        poke(12'd2004, 32'h5A5A_5A5A);
        @(negedge clk);
        start = 1'b1; base_addr = 32'd300; count = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({Address, Write_data, Mem_read, Mem_write, busy, done, max_value, max_index} !== 116'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got addr=%h rd=%b busy=%b max=%h idx=%h, want all 0",
                     Address, Mem_read, busy, max_value, max_index);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (mem[2000] !== 32'hA5A5_A5A5 || mem[2004] !== 32'h5A5A_5A5A) begin
            bad++; $display("FAIL midreset_no_write: mem2000=%h mem2004=%h want a5a5a5a5/5a5a5a5a", mem[2000], mem[2004]);
        end
        run_scan(32'd300, 16'd10, d, r, w, bth);
        total++;
        if (d !== 10 + LAT || max_value !== 32'd1000 || max_index !== 16'd7) begin
            bad++; $display("FAIL midreset_rescan: done=%0d max=%0d idx=%0d want %0d/1000/7", d, max_value, max_index, 10 + LAT);
        end
    endtask

    task automatic test_held_start();
        int d1, d2, rs, nrd1;
        logic [31:0] v1, raddr;
        d1 = -1; d2 = -1; rs = -1; nrd1 = 0; v1 = 32'd0; raddr = 32'd0;
        poke(12'd400, 32'd5);
        poke(12'd401, 32'd9);
        poke(12'd500, -32'sd1);
        poke(12'd501, 32'd40);
        poke(12'd502, 32'd40);
        @(negedge clk);
        start = 1'b1; base_addr = 32'd400; count = 16'd2;
        @(negedge clk);
        base_addr = 32'd500; count = 16'd3;
        for (int n = 1; n <= 100; n++) begin
            if (d1 < 0 && Mem_read) nrd1++;
            if (d1 < 0 && done) begin d1 = n; v1 = max_value; end
            else if (d1 > 0 && rs < 0 && Mem_read) begin rs = n; raddr = Address; start = 1'b0; end
            else if (rs > 0 && done) begin d2 = n; break; end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (d1 !== 2 + LAT || nrd1 !== 2 || v1 !== 32'd9) begin
            bad++; $display("FAIL held_first_scan: done=%0d reads=%0d max=%0d want %0d/2/9", d1, nrd1, v1, 2 + LAT);
        end
        total++;
        if (rs !== d1 + 2 || raddr !== 32'd500) begin
            bad++; $display("FAIL held_retrigger: read_cycle=%0d addr=%0d want %0d/500", rs, raddr, d1 + 2);
        end
        total++;
        if (d2 !== d1 + 4 + LAT || max_value !== 32'd40 || max_index !== 16'd1) begin
            bad++; $display("FAIL held_second_scan: done=%0d max=%0d idx=%0d want %0d/40/1", d2, max_value, max_index, d1 + 4 + LAT);
        end
    endtask

    task automatic test_count4();
        int d, r, w, bth;
        poke(12'd600, 32'd0);
        poke(12'd601, 32'd1);
        poke(12'd602, 32'h7FFF_FFFF);
        poke(12'd603, 32'h8000_0000);
        run_scan(32'd600, 16'd4, d, r, w, bth);
        total++;
        if (d !== 4 + LAT || w !== NWR) begin
            bad++; $display("FAIL c4_timing: done=%0d writes=%0d want %0d/%0d", d, w, 4 + LAT, NWR);
        end
        total++;
        if (max_value !== 32'h7FFF_FFFF || max_index !== 16'd2) begin
            bad++; $display("FAIL c4_extremes: got max=%h idx=%0d want 7fffffff/2", max_value, max_index);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negatives();
        test_count_zero();
        test_reset_mid();
        test_held_start();
        test_count4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
